// File: rtl/boot_loader.sv
// boot_loader: serial image loader sitting on the SPART processor-side bus.
// Programs the baud divisor, parses a framed image from the RX queue, writes
// 32-bit words into instruction memory and answers ACK/NAK through TX.
// The CPU is held in reset until the image is loaded and its checksum matches.
//
// Ports
//   clk, rst                 system clock, synchronous active-high reset
//   rx_q_empty, tx_q_full    SPART queue status
//   iocs_n, iorw_n, ioaddr   SPART bus control (ioaddr 00 data, 01 status,
//                            10 divisor low, 11 divisor high)
//   databus                  bidirectional byte bus, driven only on writes
//   imem_we/addr/wdata       instruction-memory write port (one-cycle strobe)
//   cpu_rst                  CPU reset hold, released in DONE
//   boot_done, boot_err      terminal status flags
//
// state    | meaning
// ---------+-----------------------------------------------------------
// INIT_LO  | write divisor low byte (ioaddr 10)
// INIT_HI  | write divisor high byte (ioaddr 11)
// SYNC     | discard bytes until 0xA5
// LEN0     | receive word count, low byte
// LEN1     | receive word count, high byte; route to DATA, CSUM or NAK
// DATA     | assemble little-endian words and write them to imem
// CSUM     | compare received checksum with the accumulated sum
// RESP     | write ACK/NAK once the TX queue has room
// DONE     | image good, CPU released (terminal)
// ERR      | load failed, CPU held (terminal)
module boot_loader #(
    parameter int          ADDR_W   = 10,
    parameter logic [12:0] BAUD_DIV = 13'h01B2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_q_empty,
    input  logic              tx_q_full,
    output logic              iocs_n,
    output logic              iorw_n,
    output logic [1:0]        ioaddr,
    inout  wire  [7:0]        databus,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst,
    output logic              boot_done,
    output logic              boot_err
);

    localparam logic [7:0]  SYNC_BYTE = 8'hA5;
    localparam logic [7:0]  ACK       = 8'h06;
    localparam logic [7:0]  NAK       = 8'h15;
    localparam logic [16:0] LEN_MAX   = 17'(2 ** ADDR_W);

    typedef enum logic [3:0] {
        S_INIT_LO, S_INIT_HI, S_SYNC, S_LEN0, S_LEN1,
        S_DATA, S_CSUM, S_RESP, S_DONE, S_ERR
    } state_t;

    state_t      state, state_nx;
    logic        rd_gap;
    logic [7:0]  len_lo;
    logic [15:0] len;
    logic [15:0] word_cnt;
    logic [1:0]  byte_idx;
    logic [23:0] word_buf;
    logic [7:0]  csum;
    logic [7:0]  resp_byte;
    logic        resp_ok;
    logic        bus_drive;
    logic [7:0]  bus_dout;
    logic        rd_state;
    logic        rd_fire;
    logic [7:0]  rx_byte;
    logic [15:0] len_rx;
    logic        len_too_big;
    logic        last_word;

    assign databus = bus_drive ? bus_dout : 8'hzz;

    // rd_gap forces one idle cycle after every read so rx_q_empty is
    // re-sampled after the SPART has popped.
    assign rd_state    = state inside {S_SYNC, S_LEN0, S_LEN1, S_DATA, S_CSUM};
    assign rd_fire     = rd_state && !rd_gap && !rx_q_empty && !rst;
    assign rx_byte     = databus;
    assign len_rx      = {rx_byte, len_lo};
    assign len_too_big = {1'b0, len_rx} > LEN_MAX;
    assign last_word   = (byte_idx == 2'd3) && ((word_cnt + 16'd1) == len);

    always_ff @(posedge clk) begin
        if (rst) state <= S_INIT_LO;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        iocs_n    = 1'b1;
        iorw_n    = 1'b1;
        ioaddr    = 2'b00;
        bus_drive = 1'b0;
        bus_dout  = 8'h00;
        cpu_rst   = 1'b1;
        boot_done = 1'b0;
        boot_err  = 1'b0;
        if (!rst) begin
            if (rd_fire) iocs_n = 1'b0;
            case (state)
                S_INIT_LO: begin
                    iocs_n    = 1'b0;
                    iorw_n    = 1'b0;
                    ioaddr    = 2'b10;
                    bus_drive = 1'b1;
                    bus_dout  = BAUD_DIV[7:0];
                    state_nx  = S_INIT_HI;
                end
                S_INIT_HI: begin
                    iocs_n    = 1'b0;
                    iorw_n    = 1'b0;
                    ioaddr    = 2'b11;
                    bus_drive = 1'b1;
                    bus_dout  = {3'b000, BAUD_DIV[12:8]};
                    state_nx  = S_SYNC;
                end
                S_SYNC: if (rd_fire && rx_byte == SYNC_BYTE) state_nx = S_LEN0;
                S_LEN0: if (rd_fire) state_nx = S_LEN1;
                S_LEN1: begin
                    if (rd_fire) begin
                        if (len_rx == 16'd0)  state_nx = S_CSUM;
                        else if (len_too_big) state_nx = S_RESP;
                        else                  state_nx = S_DATA;
                    end
                end
                S_DATA: if (rd_fire && last_word) state_nx = S_CSUM;
                S_CSUM: if (rd_fire) state_nx = S_RESP;
                S_RESP: begin
                    if (!tx_q_full) begin
                        iocs_n    = 1'b0;
                        iorw_n    = 1'b0;
                        bus_drive = 1'b1;
                        bus_dout  = resp_byte;
                        state_nx  = resp_ok ? S_DONE : S_ERR;
                    end
                end
                S_DONE: begin
                    cpu_rst   = 1'b0;
                    boot_done = 1'b1;
                end
                S_ERR: boot_err = 1'b1;
                default: state_nx = S_ERR;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_gap     <= 1'b0;
            len_lo     <= 8'h00;
            len        <= 16'd0;
            word_cnt   <= 16'd0;
            byte_idx   <= 2'd0;
            word_buf   <= 24'd0;
            csum       <= 8'h00;
            resp_byte  <= NAK;
            resp_ok    <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= 32'd0;
        end else begin
            rd_gap  <= rd_fire;
            imem_we <= 1'b0;
            // The address steps after its strobe cycle, which is always an
            // idle bus cycle, so it never collides with the LEN1 clear.
            if (imem_we) imem_addr <= imem_addr + ADDR_W'(1);
            if (rd_fire) begin
                case (state)
                    S_LEN0: len_lo <= rx_byte;
                    S_LEN1: begin
                        len       <= len_rx;
                        word_cnt  <= 16'd0;
                        byte_idx  <= 2'd0;
                        csum      <= 8'h00;
                        imem_addr <= '0;
                        resp_byte <= NAK;
                        resp_ok   <= 1'b0;
                    end
                    S_DATA: begin
                        csum     <= csum + rx_byte;
                        byte_idx <= byte_idx + 2'd1;
                        case (byte_idx)
                            2'd0: word_buf[7:0]   <= rx_byte;
                            2'd1: word_buf[15:8]  <= rx_byte;
                            2'd2: word_buf[23:16] <= rx_byte;
                            default: begin
                                imem_we    <= 1'b1;
                                imem_wdata <= {rx_byte, word_buf};
                                word_cnt   <= word_cnt + 16'd1;
                            end
                        endcase
                    end
                    S_CSUM: begin
                        resp_ok   <= (rx_byte == csum);
                        resp_byte <= (rx_byte == csum) ? ACK : NAK;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
